// File: rtl/uart_hex_display_if.sv
// Received-byte bus between the UART receiver and the hex display.
// rx_valid is a one-cycle strobe that qualifies rx_data.
interface uart_hex_display_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/uart_hex_display.sv
// Collects received hex nibbles into a digit shift register and scans them onto a
// common-anode 7-segment display; the last received byte is mirrored for the LEDs.
module uart_hex_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 27000,
    parameter int ASCII_MODE  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_hex_display_if.slave     rx,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] dig_n,
    output logic [7:0]            last_byte,
    output logic                  rx_err
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] digits_r, digits_s;
    logic [NUM_DIGITS-1:0]   lit_r, lit_s;
    logic [CNT_W-1:0]        scan_cnt_r;
    logic [IDX_W-1:0]        scan_idx_r;
    logic                    err_s;
    logic [4:0]              dec_s;
    logic [3:0]              cur_digit_s;
    logic [6:0]              seg_s;
    logic [NUM_DIGITS-1:0]   dig_s;
    logic                    dp_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    // Returns {valid, nibble}; letters map by adding 9 to the low bits of 'A'..'F' / 'a'..'f'.
    function automatic logic [4:0] ascii_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            return {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            return {1'b1, c[3:0] + 4'd9};
        end else begin
            return 5'h00;
        end
    endfunction

    // Next digit/lit-mask contents and reject flag for the byte presented this cycle.
    always_comb begin
        digits_s = digits_r;
        lit_s    = lit_r;
        err_s    = 1'b0;
        dec_s    = ascii_decode(rx.rx_data);
        if (rx.rx_valid) begin
            if (ASCII_MODE != 0) begin
                if (dec_s[4]) begin
                    digits_s      = digits_r << 4;
                    digits_s[3:0] = dec_s[3:0];
                    lit_s         = lit_r << 1;
                    lit_s[0]      = 1'b1;
                end else if (rx.rx_data == 8'h0D || rx.rx_data == 8'h0A) begin
                    digits_s = '0;
                    lit_s    = '0;
                end else begin
                    err_s = 1'b1;
                end
            end else begin
                digits_s      = digits_r << 8;
                digits_s[7:0] = rx.rx_data;
                lit_s         = lit_r << 2;
                lit_s[1:0]    = 2'b11;
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // Digit storage, lit-mask and the byte mirror.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_r  <= '0;
            lit_r     <= '0;
            last_byte <= 8'h00;
            rx_err    <= 1'b0;
        end else begin
            digits_r  <= digits_s;
            lit_r     <= lit_s;
            rx_err    <= err_s;
            if (rx.rx_valid) begin
                last_byte <= rx.rx_data;
            end
        end
    end

    // Refresh timer: each digit is held for REFRESH_DIV cycles before moving on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_r <= '0;
            scan_idx_r <= '0;
        end else if (scan_cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
            scan_cnt_r <= '0;
            scan_idx_r <= (scan_idx_r == IDX_W'(NUM_DIGITS - 1)) ? IDX_W'(0) : scan_idx_r + IDX_W'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r + CNT_W'(1);
        end
    end

    // Segment/enable pattern for the digit under the scan pointer; unlit digits stay dark.
    always_comb begin
        cur_digit_s = digits_r[{scan_idx_r, 2'b00} +: 4];
        dig_s       = {NUM_DIGITS{1'b1}};
        seg_s       = 7'h7F;
        dp_s        = ~((scan_idx_r == IDX_W'(0)) && (&lit_r));
        if (lit_r[scan_idx_r]) begin
            dig_s[scan_idx_r] = 1'b0;
            seg_s             = hex_to_seg(cur_digit_s);
        end else begin
            dig_s = {NUM_DIGITS{1'b1}};
            seg_s = 7'h7F;
        end
    end

    // Enables and segments share one register stage so they switch together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
            dig_n <= {NUM_DIGITS{1'b1}};
        end else begin
            seg_n <= seg_s;
            dp_n  <= dp_s;
            dig_n <= dig_s;
        end
    end

endmodule
